sram_access_ctrl: RTL and testbench
===================================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, the SRAM address width (2**ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the SRAM word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_write (in, 1; 1=write, 0=read), req_addr (in, ADDR_WIDTH) and req_wdata (in, DATA_WIDTH) as the request channel.
REQ-006 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1) and rsp_rdata (out, DATA_WIDTH) as the read-response channel.
REQ-007 SHALL have SRAM-side ports mem_we (out, 1), mem_oe (out, 1), mem_address (out, ADDR_WIDTH), mem_data_in (out, DATA_WIDTH) and mem_data_out (in, DATA_WIDTH; registered SRAM output, updated one edge after mem_oe is sampled high).
REQ-008 SHALL have ports clear_start (in, 1) and clear_busy (out, 1); these are functional only per REQ-026.

Function
REQ-009 SHALL implement FSM states IDLE, WRITE, READ, CAPT, RESP and CLEAR.
REQ-010 SHALL drive req_ready=1 only in IDLE (combinational from state); a request is accepted on an edge where req_valid && req_ready.
REQ-011 SHALL register req_addr, req_wdata and req_write on acceptance; later changes on the request inputs have no effect.
REQ-012 Write: IDLE->WRITE; in WRITE, mem_we=1, mem_address=the captured address, mem_data_in=the captured data; WRITE->IDLE after one cycle, which makes a write 2 cycles acceptance-to-ready.
REQ-013 Read: IDLE->READ (mem_oe=1 for exactly one cycle) ->CAPT (rsp_rdata<=mem_data_out at end of cycle) ->RESP.
REQ-014 SHALL assert rsp_valid only in RESP, which makes rsp_valid high 3 cycles after the acceptance edge.
REQ-015 SHALL hold rsp_valid and rsp_rdata stable in RESP until rsp_ready=1, then go RESP->IDLE; req_ready rises the next cycle.
REQ-016 SHALL never assert mem_we and mem_oe in the same cycle; both are 0 in IDLE, CAPT and RESP.
REQ-017 SHALL hold mem_address and mem_data_in at their last driven values when not writing or reading.
REQ-018 SHALL keep rsp_rdata holding the last read word after RESP exits.
REQ-019 The request channel stays stalled while RESP waits; back-to-back requests are not pipelined.

Reset
REQ-020 On rst (asynchronously): state=IDLE, mem_we=0, mem_oe=0, mem_address=0, mem_data_in=0, rsp_valid=0, rsp_rdata=0, clear_busy=0 and the clear counter=0.
REQ-021 Because state is IDLE during reset, req_ready=1 during reset; requests are not accepted while rst=1.
REQ-022 Reset mid-operation (any state) SHALL abort the operation; a pending response is discarded and no further mem_we or mem_oe pulse is issued.

Configuration
REQ-023 Macro SRAM_ACCESS_CTRL_CLEAR_EN SHALL compile in the clear sequencer.
REQ-024 With the macro defined: clear_start=1 in IDLE enters CLEAR; CLEAR drives mem_we=1, mem_data_in=0 and mem_address=counter, incrementing 0..2**ADDR_WIDTH-1, one word per cycle.
REQ-025 With the macro defined: after the last address the counter wraps to 0 and the FSM returns to IDLE; clear_busy=1 exactly while in CLEAR; clear_start outside IDLE is ignored; if clear_start and req_valid are both high in IDLE, clear wins and the request is not accepted.
REQ-026 Without the macro: clear_start is ignored, clear_busy is tied 0, the CLEAR state and counter are absent, and the ports remain.

Structure
REQ-027 The state enumeration and default width constants SHALL live in shared package sram_pkg.
REQ-028 There SHALL be no sub-module; the bench instantiates sram_access_ctrl alongside simple_sram.

Verification
REQ-029 Write 0xA5 to addr 3, then read addr 3 -> rsp_valid 3 cycles after read acceptance, rsp_rdata=0xA5.
REQ-030 Read addr 7 with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; after rsp_ready=1, IDLE next cycle.
REQ-031 Write 0x11/0x22/0x33 to addrs 0/15/8 back-to-back with req_valid held -> one acceptance per 2 cycles; readback matches, including addr 15.
REQ-032 Assert rst in READ -> mem_oe=0 and rsp_valid=0 immediately; no response after release.
REQ-033 With CLEAR_EN: fill all 16 words with 0xFF, then pulse clear_start together with req_valid -> clear_busy high for 16 cycles, request deferred; all reads then return 0x00.
REQ-034 Every test -> mem_we && mem_oe never observed high together.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants for the SRAM access controller: default geometry and
// FSM state encodings.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 4;
   localparam int unsigned SRAM_DATA_W = 8;
   localparam int unsigned STATE_W     = 3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_CAPT  = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;
   localparam logic [2:0] ST_CLEAR = 3'd5;

endpackage

// File: rtl/simple_sram.sv
// Single-port synchronous SRAM with a registered read port: dout updates on
// the edge that samples oe high.
module simple_sram
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
   parameter int unsigned DATA_WIDTH = SRAM_DATA_W
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  oe,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port and registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      if (oe) begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/sram_access_ctrl.sv
// Request/response front end for a single-port registered-output SRAM.
// Optional clear sequencer (zero-fills every word) is compiled in with
// `define SRAM_ACCESS_CTRL_CLEAR_EN.
module sram_access_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
   parameter int unsigned DATA_WIDTH = SRAM_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  mem_we,
   output logic                  mem_oe,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  clear_start,
   output logic                  clear_busy
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic               clear_go_c;
   logic               accept_c;

   assign req_ready = (state == ST_IDLE);

`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
   // Next address to be zeroed; wraps to 0 as the last word is issued
   logic [ADDR_WIDTH-1:0] clr_cnt;

   assign clear_go_c = clear_start && (state == ST_IDLE);
`else
   logic unused_clear_start;

   assign unused_clear_start = clear_start;
   assign clear_go_c         = 1'b0;
   assign clear_busy         = 1'b0;
`endif

   // Clear has priority over a simultaneous request
   assign accept_c = req_valid && req_ready && !clear_go_c;

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
            if (clear_go_c) begin
               state_nxt = ST_CLEAR;
            end else
`endif
            if (accept_c) begin
               state_nxt = req_write ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: state_nxt = ST_IDLE;
         ST_READ:  state_nxt = ST_CAPT;
         ST_CAPT:  state_nxt = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
         ST_CLEAR: begin
            if (clr_cnt == '0) begin
               state_nxt = ST_IDLE;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered strobes, decoded from the next state so
   // they line up exactly with the state they belong to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         mem_we    <= 1'b0;
         mem_oe    <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         mem_oe    <= (state_nxt == ST_READ);
         rsp_valid <= (state_nxt == ST_RESP);
`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
         mem_we    <= (state_nxt == ST_WRITE) || (state_nxt == ST_CLEAR);
`else
         mem_we    <= (state_nxt == ST_WRITE);
`endif
      end
   end

   // SRAM address/data: captured on acceptance (or clear step), held otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_address <= '0;
         mem_data_in <= '0;
      end else if (accept_c) begin
         mem_address <= req_addr;
         if (req_write) begin
            mem_data_in <= req_wdata;
         end
`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
      end else if (state_nxt == ST_CLEAR) begin
         mem_address <= clr_cnt;
         mem_data_in <= '0;
`endif
      end
   end

   // Read data capture; holds the last read word afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= '0;
      end else if (state == ST_CAPT) begin
         rsp_rdata <= mem_data_out;
      end
   end

`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
   // Clear counter and busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt    <= '0;
         clear_busy <= 1'b0;
      end else begin
         clear_busy <= (state_nxt == ST_CLEAR);
         if (state_nxt == ST_CLEAR) begin
            clr_cnt <= ADDR_WIDTH'(clr_cnt + 1'b1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed self-checking bench for sram_access_ctrl driving a simple_sram.
// Clear-sequencer checks follow `define SRAM_ACCESS_CTRL_CLEAR_EN.
module tb_sram_access_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       mem_we;
   logic       mem_oe;
   logic [3:0] mem_address;
   logic [7:0] mem_data_in;
   logic [7:0] mem_data_out;
   logic       clear_start;
   logic       clear_busy;

   int errors   = 0;
   int checks   = 0;
   int overlap  = 0;
   int rsp_seen = 0;
   int oe_seen  = 0;
   bit watch    = 1'b0;

   sram_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .mem_we       (mem_we),
      .mem_oe       (mem_oe),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .clear_start  (clear_start),
      .clear_busy   (clear_busy)
   );

   simple_sram #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) u_sram (
      .clk  (clk),
      .we   (mem_we),
      .oe   (mem_oe),
      .addr (mem_address),
      .din  (mem_data_in),
      .dout (mem_data_out)
   );

   always #5 clk = ~clk;

   // Watch for illegal strobe overlap and for stray activity after reset
   always @(negedge clk) begin
      if (mem_we && mem_oe) overlap++;
      if (watch && rsp_valid) rsp_seen++;
      if (watch && mem_oe) oe_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check("idle_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      wait_idle();
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("wr_we", 32'(mem_we), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input int hold);
      wait_idle();
      req_valid = 1'b1; req_write = 1'b0; req_addr = a; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = ~a;
      check("rd_oe", 32'(mem_oe), 32'd1);
      check("rd_addr", 32'(mem_address), 32'(a));
      check("rd_busy", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("capt_oe", 32'(mem_oe), 32'd0);
      check("capt_valid", 32'(rsp_valid), 32'd0);
      check("capt_addr", 32'(mem_address), 32'(a));
      @(posedge clk); #1;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_rdata", 32'(rsp_rdata), 32'(exp));
         check("hold_stall", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_done", 32'(rsp_valid), 32'd0);
      check("rsp_idle", 32'(req_ready), 32'd1);
      check("rdata_kept", 32'(rsp_rdata), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [3:0] last;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; rsp_ready = 1'b0; clear_start = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_oe", 32'(mem_oe), 32'd0);
      check("rst_addr", 32'(mem_address), 32'd0);
      check("rst_wdata", 32'(mem_data_in), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_busy", 32'(clear_busy), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Write A5 to 3 and read it back
      wait_idle();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = 8'h00;
      check("w3_we", 32'(mem_we), 32'd1);
      check("w3_addr", 32'(mem_address), 32'd3);
      check("w3_data", 32'(mem_data_in), 32'hA5);
      check("w3_busy", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("w3_done_we", 32'(mem_we), 32'd0);
      check("w3_done_ready", 32'(req_ready), 32'd1);
      check("w3_addr_held", 32'(mem_address), 32'd3);
      do_read(4'd3, 8'hA5, 0);

      // Read of addr 7 with response back-pressure
      do_write(4'd7, 8'h5C);
      do_read(4'd7, 8'h5C, 5);

      // Back-to-back writes with req_valid held high
      wait_idle();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd0; req_wdata = 8'h11;
      @(posedge clk); #1;
      req_addr = 4'd15; req_wdata = 8'h22;
      check("b2b0_we", 32'(mem_we), 32'd1);
      check("b2b0_addr", 32'(mem_address), 32'd0);
      check("b2b0_data", 32'(mem_data_in), 32'h11);
      @(posedge clk); #1;
      check("b2b0_gap_we", 32'(mem_we), 32'd0);
      check("b2b0_gap_rdy", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_addr = 4'd8; req_wdata = 8'h33;
      check("b2b1_we", 32'(mem_we), 32'd1);
      check("b2b1_addr", 32'(mem_address), 32'd15);
      check("b2b1_data", 32'(mem_data_in), 32'h22);
      @(posedge clk); #1;
      check("b2b1_gap_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("b2b2_we", 32'(mem_we), 32'd1);
      check("b2b2_addr", 32'(mem_address), 32'd8);
      check("b2b2_data", 32'(mem_data_in), 32'h33);
      @(posedge clk); #1;
      do_read(4'd0, 8'h11, 0);
      do_read(4'd15, 8'h22, 0);
      do_read(4'd8, 8'h33, 1);

      // Reset asserted during READ aborts the access
      wait_idle();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("ab_oe", 32'(mem_oe), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ab_oe_low", 32'(mem_oe), 32'd0);
      check("ab_valid_low", 32'(rsp_valid), 32'd0);
      check("ab_ready", 32'(req_ready), 32'd1);
      check("ab_addr", 32'(mem_address), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      watch = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      watch = 1'b0;
      check("ab_no_rsp", 32'(rsp_seen), 32'd0);
      check("ab_no_oe", 32'(oe_seen), 32'd0);
      do_read(4'd15, 8'h22, 0);

`ifdef SRAM_ACCESS_CTRL_CLEAR_EN
      // Fill, then clear with a competing request
      for (int a = 0; a < 16; a++) do_write(4'(a), 8'hFF);
      do_read(4'd9, 8'hFF, 0);
      wait_idle();
      clear_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
      @(posedge clk); #1;
      clear_start = 1'b0;
      check("clr_defer", 32'(req_ready), 32'd0);
      check("clr_first_addr", 32'(mem_address), 32'd0);
      check("clr_zero_data", 32'(mem_data_in), 32'd0);
      check("clr_oe", 32'(mem_oe), 32'd0);
      n = 0; last = '0;
      while (clear_busy && n < 40) begin
         n++;
         last = mem_address;
         @(posedge clk); #1;
      end
      check("clr_cycles", 32'(n), 32'd16);
      check("clr_last_addr", 32'(last), 32'd15);
      check("clr_pending_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      for (int a = 0; a < 16; a++) do_read(4'(a), 8'h00, 0);
`else
      // Clear request is ignored; the simultaneous write goes through
      wait_idle();
      clear_start = 1'b1; req_valid = 1'b1; req_write = 1'b1;
      req_addr = 4'd2; req_wdata = 8'h77;
      @(posedge clk); #1;
      clear_start = 1'b0; req_valid = 1'b0;
      check("noclr_busy", 32'(clear_busy), 32'd0);
      check("noclr_we", 32'(mem_we), 32'd1);
      check("noclr_addr", 32'(mem_address), 32'd2);
      @(posedge clk); #1;
      do_read(4'd2, 8'h77, 0);
`endif

      check("we_oe_overlap", 32'(overlap), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
